// File: rtl/load_c_pkg.sv
// rtl/load_c_pkg.sv - shared types and constants for the load_c scheduler
package load_c_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] TERM_VAL = {CNT_W{1'b1}};
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/load_c_sched_if.sv
// rtl/load_c_sched_if.sv - requester and counter signals around the load_c scheduler
// req/val/gnt/done : requester side (level request, packed start values, pulses back)
// busy             : a job owns the counter
// load/load_val    : to load_c.load_i / load_c.load_val_i
// count            : from load_c.count_o
interface load_c_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] val;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic                     load;
    logic [CNT_W-1:0]         load_val;
    logic [CNT_W-1:0]         count;

    // master: requesters plus the counter instance; slave: the scheduler
    modport master (output req, val, count, input gnt, done, busy, load, load_val);
    modport slave  (input req, val, count, output gnt, done, busy, load, load_val);
endinterface

// File: rtl/load_c_sched_rr_arbiter.sv
// rtl/load_c_sched_rr_arbiter.sv - combinational round-robin arbiter
// req_i     : request vector
// rr_ptr_i  : index holding highest priority
// grant_o   : one-hot grant (zero when no request)
// winner_o  : index of the granted requester
// any_req_o : at least one request present
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_req_o
);

    int unsigned      idx;
    logic [IDX_W-1:0] idx_w;

    always_comb begin
        grant_o   = '0;
        winner_o  = '0;
        idx       = 0;
        idx_w     = '0;
        any_req_o = |req_i;
        // Scan from the farthest offset back toward rr_ptr so the closest
        // requester is the last one written and therefore wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx   = (int'(rr_ptr_i) + i) % NUM_REQ;
            idx_w = IDX_W'(idx);
            if (req_i[idx_w]) begin
                winner_o = idx_w;
            end
        end
        if (any_req_o) begin
            grant_o[winner_o] = 1'b1;
        end
    end

endmodule

// File: rtl/load_c_sched.sv
// rtl/load_c_sched.sv - round-robin owner scheduler for a shared load_c counter
// clk   : rising-edge clock
// reset : asynchronous active-high reset
// bus   : slave side of load_c_sched_if (requests in, grant/done/busy out,
//         load/load_val to the counter, count back from it); all outputs registered
module load_c_sched #(
    parameter int NUM_REQ = load_c_pkg::DEF_NUM_REQ,
    parameter int CNT_W   = load_c_pkg::CNT_W,
    parameter logic [CNT_W-1:0] TERM_VAL = {CNT_W{1'b1}}
) (
    input  logic           clk,
    input  logic           reset,
    load_c_sched_if.slave  bus
);
    import load_c_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               load_q, load_d;
    logic [CNT_W-1:0]   load_val_q, load_val_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   winner;
    logic               any_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (bus.req),
        .rr_ptr_i  (rr_ptr_q),
        .grant_o   (grant),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        gnt_d      = '0;
        done_d     = '0;
        load_d     = 1'b0;
        load_val_d = load_val_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = LOAD;
                    owner_d    = winner;
                    gnt_d      = grant;
                    load_d     = 1'b1;
                    load_val_d = bus.val[int'(winner)*CNT_W +: CNT_W];
                    // Last winner drops to lowest priority next time.
                    rr_ptr_d   = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            // Counter samples load here; requests are ignored until back in IDLE.
            LOAD: state_d = RUN;
            RUN: begin
                if (bus.count == TERM_VAL) begin
                    state_d         = IDLE;
                    done_d[owner_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.load     = load_q;
    assign bus.load_val = load_val_q;

endmodule

// File: tb/tb_load_c_sched.sv
// tb/tb_load_c_sched.sv - directed self-checking bench for load_c_sched
module tb_load_c_sched;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] cnt = 4'h0;
    int vectors = 0;
    int errs = 0;

    load_c_sched_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

    load_c_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // load_c model: load or increment mod 16, never reset
    always @(posedge clk) begin
        if (bus.load) cnt <= bus.load_val;
        else          cnt <= cnt + 4'h1;
    end
    assign bus.count = cnt;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick until a grant appears; returns ticks taken.
    task automatic wait_gnt(input int max, output int n);
        n = 0;
        while (bus.gnt == 4'b0 && n < max) begin
            tick();
            n++;
        end
    endtask

    // Current tick shows the grant cycle.
    task automatic grant_phase(input int k, input logic [3:0] v, input string tag);
        logic [3:0] m;
        m = 4'b0001 << k;
        chk({tag, "_gnt"}, bus.gnt, m);
        chk({tag, "_load"}, {bus.load, bus.busy, bus.load_val}, {1'b1, 1'b1, v});
        chk({tag, "_nodone"}, bus.done, 4'b0);
        bus.req[k] = 1'b0;
    endtask

    // Ticks until done; ends on the tick where done is visible.
    task automatic run_phase(input int k, input logic [3:0] v, input string tag);
        int lat;
        logic [3:0] last_cnt;
        logic stray;
        tick();
        chk({tag, "_load1"}, {bus.load, bus.busy, bus.load_val, bus.gnt}, {1'b0, 1'b1, v, 4'b0});
        lat = 1;
        stray = 1'b0;
        last_cnt = bus.count;
        while (bus.done == 4'b0 && lat < 40) begin
            if (bus.gnt != 4'b0 || bus.load || !bus.busy) stray = 1'b1;
            last_cnt = bus.count;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'(4'hF - v) + 32'd2);
        chk({tag, "_done"}, {bus.done, bus.gnt, bus.busy}, {4'b0001 << k, 4'b0, 1'b0});
        chk({tag, "_lastcnt"}, last_cnt, 4'hF);
        chk({tag, "_stray"}, stray, 1'b0);
    endtask

    initial begin
        int n;
        logic [3:0] vals [4];
        int order [4];

        // Reset held with req0 pending
        bus.req = 4'b0001;
        bus.val = 16'h0005;
        tick();
        chk("rst_outs_a", {bus.gnt, bus.done, bus.busy, bus.load, bus.load_val}, '0);
        tick();
        chk("rst_outs_b", {bus.gnt, bus.done, bus.busy, bus.load, bus.load_val}, '0);
        reset = 1'b0;
        tick();
        grant_phase(0, 4'h5, "rst_req0");
        run_phase(0, 4'h5, "rst_req0");

        // Single job, req1 val C
        tick();
        chk("idle_after_done", {bus.busy, bus.done}, 5'b0);
        bus.val[7:4] = 4'hC;
        bus.req[1] = 1'b1;
        wait_gnt(5, n);
        chk("j1_gnt_delay", n, 1);
        grant_phase(1, 4'hC, "j1");
        run_phase(1, 4'hC, "j1");

        // Boundary values F and 0
        tick();
        bus.val[11:8] = 4'hF;
        bus.req[2] = 1'b1;
        wait_gnt(5, n);
        grant_phase(2, 4'hF, "vF");
        run_phase(2, 4'hF, "vF");
        tick();
        bus.val[15:12] = 4'h0;
        bus.req[3] = 1'b1;
        wait_gnt(5, n);
        grant_phase(3, 4'h0, "v0");
        run_phase(3, 4'h0, "v0");

        // All four together: 0,3,6,9 granted 0,1,2,3 with one idle cycle between
        tick();
        vals = '{4'h0, 4'h3, 4'h6, 4'h9};
        bus.val = {vals[3], vals[2], vals[1], vals[0]};
        bus.req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_gnt(5, n);
            chk($sformatf("all_gap%0d", j), n, 1);
            grant_phase(j, vals[j], $sformatf("all%0d", j));
            run_phase(j, vals[j], $sformatf("all%0d", j));
        end

        // Fairness: req0 and req2 keep requesting, expect 0,2,0,2
        tick();
        bus.val[3:0]  = 4'hE;
        bus.val[11:8] = 4'hD;
        bus.req = 4'b0101;
        order = '{0, 2, 0, 2};
        for (int j = 0; j < 4; j++) begin
            wait_gnt(5, n);
            chk($sformatf("fair_gap%0d", j), n, 1);
            grant_phase(order[j], (order[j] == 0) ? 4'hE : 4'hD, $sformatf("fair%0d", j));
            run_phase(order[j], (order[j] == 0) ? 4'hE : 4'hD, $sformatf("fair%0d", j));
            if (j < 3) bus.req[order[j]] = 1'b1;
            else       bus.req = 4'b0;
        end

        // Reset mid-RUN at count 7 with req3 pending
        tick();
        bus.val[7:4]   = 4'h4;
        bus.val[15:12] = 4'hB;
        bus.req[1] = 1'b1;
        wait_gnt(5, n);
        grant_phase(1, 4'h4, "mid");
        n = 0;
        while (bus.count != 4'h7 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_reach7", {bus.count, bus.busy}, {4'h7, 1'b1});
        bus.req[3] = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_async_clr", {bus.gnt, bus.done, bus.busy, bus.load, bus.load_val}, '0);
        n = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (bus.done != 4'b0 || bus.busy || bus.load) n++;
        end
        chk("mid_no_done", n, 0);
        reset = 1'b0;
        tick();
        grant_phase(3, 4'hB, "post_rst");
        run_phase(3, 4'hB, "post_rst");

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/load_c_sched.md
Name: load_c_sched

Overview:
- Round-robin scheduler that shares one loadable up-counter (load_c) between NUM_REQ requesters.
- Each requester submits a start value. The scheduler grants one requester, loads the counter with that value, and watches the count until it reaches TERM_VAL.
- It then pulses done to the owner and frees the counter.
- Sits between requester blocks and the load_c instance; drives its load_i/load_val_i and observes count_o.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, counter width; must match load_c.
- TERM_VAL, {CNT_W{1'b1}} (4'hF), terminal count that ends a job.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester level request; held with val_i stable until gnt_o.
- val_i  input  NUM_REQ*CNT_W  packed start values; requester k uses bits [k*CNT_W +: CNT_W].
- gnt_o  output  NUM_REQ  one-hot, one-cycle grant pulse.
- done_o  output  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- busy_o  output  1  high while a job owns the counter (states LOAD and RUN).
- load_o  output  1  to load_c.load_i.
- load_val_o  output  CNT_W  to load_c.load_val_i.
- count_i  input  CNT_W  from load_c.count_o.

Behaviour:
- Counter model: on each posedge, load_c loads load_val_i if load_i=1, else increments by 1 modulo 2^CNT_W.
- All outputs are registered.
- Reset values: state=IDLE, gnt_o=0, done_o=0, busy_o=0, load_o=0, load_val_o=0, rr_ptr=0, owner=0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - If any req_i is set, pick a winner by round-robin starting at rr_ptr.
  - Next edge: state=LOAD, owner=winner, gnt_o[winner]=1, load_o=1, load_val_o=val_i[winner], rr_ptr=(winner+1) mod NUM_REQ.
  - If req_i is zero, stay in IDLE.
- LOAD: exactly one cycle (load_c samples load_o here). Next edge: state=RUN, load_o=0, gnt_o=0. load_val_o holds its value.
- RUN:
  - Sample count_i each edge.
  - On the edge where count_i==TERM_VAL: done_o[owner]=1 for one cycle, state=IDLE.
  - Otherwise stay in RUN.
- Latency: done_o rises (TERM_VAL - V) + 2 cycles after gnt_o rises, where V is the loaded value.
  - V=TERM_VAL gives 2 cycles.
  - V=0 gives 17 cycles for CNT_W=4.
- Back-to-back jobs: after a done, IDLE takes one cycle to arbitrate. There is one idle cycle (load_o=0) between jobs.
- Requester rules:
  - A requester drops req_i in the cycle after it sees gnt_o.
  - req_i is ignored while busy_o=1, including the owner's.
  - A req_i still high when the scheduler returns to IDLE is treated as a new request.
- Arbitration:
  - Priority order is rr_ptr, rr_ptr+1, ..., wrapping.
  - The last winner always gets lowest priority on the next arbitration.
  - Several requests arriving in the same cycle are resolved only by rr_ptr.
- Reset mid-job: all state clears immediately and asynchronously. No done_o is issued for the aborted job. load_o drops to 0, so the counter free-runs.
- gnt_o and done_o are never high in the same cycle. At most one bit of each is set.

Decomposition:
- Package load_c_pkg holds:
  - state enum sched_state_t {IDLE, LOAD, RUN}.
  - Constants CNT_W=4, TERM_VAL=4'hF, default NUM_REQ=4.
- Sub-module rr_arbiter (NUM_REQ): combinational grant from req and rr_ptr.
  - Outputs: one-hot grant, winner index, any_req.
  - Reused by other shared-resource schedulers.

Test Plan:
- Reset with req_i=4'b0001 held, then release reset:
  - Grant goes to req0 with load_val_o=val0.
  - No outputs are high while reset=1.
- Single job, req1 with val=4'hC:
  - gnt_o=4'b0010, then load_o high for 1 cycle with load_val_o=C.
  - Count runs C,D,E,F.
  - done_o=4'b0010 exactly 5 cycles after gnt_o; busy_o drops with done.
- Boundary values:
  - val=4'hF gives done 2 cycles after gnt.
  - val=4'h0 gives done 17 cycles after gnt.
  - No wrap past F before done.
- All four requesters request together with values 0,3,6,9:
  - Grants in order 0,1,2,3.
  - Each done precedes the next gnt by exactly 1 idle cycle.
  - busy_o is never low for more than 1 cycle until all are done.
- Fairness: req0 re-asserts immediately after each of its grants while req2 is also held:
  - Grants alternate 0,2,0,2.
  - No requester is granted twice in a row while the other waits.
- Reset asserted mid-RUN (count=4'h7):
  - Outputs clear the same cycle; no done_o is issued.
  - After release, a pending req3 is granted first.
